// File: rtl/pc_sequencer.sv
// Program counter owner for the 5-stage pipeline: picks the next fetch address from
// sequential, J/JAL, JR and taken-branch sources, and drives flushes and redirect bookkeeping.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_BOOT | first cycle after reset; no fetch, pc holds, requests ignored
// ST_RUN  | normal fetch; next pc chosen by branch > jr > jump > stall > seq
module pc_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 jump_req,
    input  logic [25:0]          jump_index,
    input  logic                 jr_req,
    input  logic [31:0]          jr_target,
    input  logic [31:0]          id_pc_plus4,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_offset,
    input  logic [31:0]          ex_pc_plus4,
    output logic [31:0]          pc,
    output logic [31:0]          pc_plus4,
    output logic                 fetch_valid,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic [1:0]           redirect_src,
    output logic                 misalign_err,
    output logic [CNT_WIDTH-1:0] redirect_count
);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] SRC_SEQ    = 2'd0;
    localparam logic [1:0] SRC_JUMP   = 2'd1;
    localparam logic [1:0] SRC_JR     = 2'd2;
    localparam logic [1:0] SRC_BRANCH = 2'd3;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_next;
    logic [1:0]  src_next;
    logic        redirect;
    logic        misalign_set;

    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_aligned;

    assign pc_plus4      = pc + 32'd4;
    // Offset is a word count, so the shift drops its top two bits by design.
    assign branch_target = ex_pc_plus4 + {branch_offset[29:0], 2'b00};
    assign jump_target   = {id_pc_plus4[31:28], jump_index, 2'b00};
    assign jr_aligned    = {jr_target[31:2], 2'b00};

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        src_next     = SRC_SEQ;
        redirect     = 1'b0;
        misalign_set = 1'b0;
        fetch_valid  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;

        if (!reset) begin
            case (state)
                ST_BOOT: begin
                    state_next = ST_RUN;
                end
                ST_RUN: begin
                    fetch_valid = 1'b1;
                    if (branch_taken) begin
                        pc_next     = branch_target;
                        src_next    = SRC_BRANCH;
                        redirect    = 1'b1;
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (jr_req && !stall) begin
                        pc_next      = jr_aligned;
                        src_next     = SRC_JR;
                        redirect     = 1'b1;
                        flush_if_id  = 1'b1;
                        misalign_set = (jr_target[1:0] != 2'b00);
                    end else if (jump_req && !stall) begin
                        pc_next     = jump_target;
                        src_next    = SRC_JUMP;
                        redirect    = 1'b1;
                        flush_if_id = 1'b1;
                    end else if (!stall) begin
                        pc_next = pc_plus4;
                    end
                end
                default: begin
                    state_next = ST_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_BOOT;
            pc             <= RESET_PC;
            redirect_src   <= SRC_SEQ;
            misalign_err   <= 1'b0;
            redirect_count <= '0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            redirect_src <= src_next;
            if (misalign_set) begin
                misalign_err <= 1'b1;
            end
            if (redirect && (redirect_count != {CNT_WIDTH{1'b1}})) begin
                redirect_count <= redirect_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
